// File: rtl/cpu_run_mon_pkg.sv
// Shared types and constants for the CPU run monitor.
// Optional feature macro: RUN_MON_TRACE_EN (pc history ring in cpu_run_monitor).
package cpu_run_mon_pkg;

  localparam int PC_W        = 16;
  localparam int CNT_W       = 32;
  localparam int TRACE_DEPTH = 8;
  localparam int TRACE_IDX_W = 3;
  localparam int HOLD_W      = 8;
  localparam int SPIN_W      = 16;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } run_state_e;

  // Ring slot holding the entry idx steps back from the newest one.
  function automatic logic [TRACE_IDX_W-1:0] trace_slot(
    input logic [TRACE_IDX_W-1:0] wr_ptr,
    input logic [TRACE_IDX_W-1:0] idx
  );
    return wr_ptr - 3'd1 - idx;
  endfunction

endpackage

// File: rtl/run_rst_sync.sv
// Reset release synchronizer plus CPU reset hold stretcher.
// hold_done pulses on the edge where the FSM should leave HOLD.
module run_rst_sync
  import cpu_run_mon_pkg::*;
#(
  parameter logic [HOLD_W-1:0] RST_HOLD_CYCLES = 8'd4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold_en,
  output logic hold_done
);

  logic [1:0]        sync_r;
  logic [HOLD_W-1:0] hold_cnt_r;

  assign hold_done = hold_en && sync_r[1] && (hold_cnt_r == RST_HOLD_CYCLES - 8'd1);

  // Two-flop synchronizer: assertion is immediate, release is delayed two edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], 1'b1};
    end
  end

  // Hold counter: counts HOLD edges after synchronized release, idle at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_r <= {HOLD_W{1'b0}};
    end else if (hold_en && sync_r[1]) begin
      if (hold_done) begin
        hold_cnt_r <= {HOLD_W{1'b0}};
      end else begin
        hold_cnt_r <= hold_cnt_r + 8'd1;
      end
    end else begin
      hold_cnt_r <= {HOLD_W{1'b0}};
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// CPU run monitor: holds the CPU in reset, supervises the run for halt,
// timeout and pc spin, and optionally keeps a pc change history.
// Optional feature macro: RUN_MON_TRACE_EN (8-entry pc history ring).
module cpu_run_monitor
  import cpu_run_mon_pkg::*;
#(
  parameter logic [HOLD_W-1:0] RST_HOLD_CYCLES = 8'd4,
  parameter logic [CNT_W-1:0]  TIMEOUT_CYCLES  = 32'd100000,
  parameter logic [SPIN_W-1:0] SPIN_LIMIT      = 16'd16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   restart,
  input  logic                   hlt,
  input  logic [PC_W-1:0]        pc,
  output logic                   cpu_rst_n,
  output logic                   done,
  output logic                   timeout,
  output logic                   spin,
  output logic [PC_W-1:0]        halt_pc,
  output logic [CNT_W-1:0]       cycle_cnt,
  input  logic [TRACE_IDX_W-1:0] trace_idx,
  output logic [PC_W-1:0]        trace_pc
);

  run_state_e        state_r;
  logic              hold_done_s;
  logic [PC_W-1:0]   prev_pc_r;
  logic              seen_r;      // at least one RUN cycle seen since HOLD
  logic [SPIN_W-1:0] spin_cnt_r;
  logic              pc_same_s;

  // The first RUN cycle has no valid previous pc, so it always counts as a change.
  assign pc_same_s = seen_r && (pc == prev_pc_r);

  run_rst_sync #(
    .RST_HOLD_CYCLES(RST_HOLD_CYCLES)
  ) u_rst_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold_en  (state_r == ST_HOLD),
    .hold_done(hold_done_s)
  );

  // Run supervisor FSM with its counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_HOLD;
      cpu_rst_n  <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      spin       <= 1'b0;
      halt_pc    <= {PC_W{1'b0}};
      cycle_cnt  <= {CNT_W{1'b0}};
      prev_pc_r  <= {PC_W{1'b0}};
      seen_r     <= 1'b0;
      spin_cnt_r <= {SPIN_W{1'b0}};
    end else begin
      case (state_r)
        ST_HOLD: begin
          seen_r <= 1'b0;
          if (hold_done_s) begin
            state_r   <= ST_RUN;
            cpu_rst_n <= 1'b1;
          end else begin
            state_r   <= ST_HOLD;
            cpu_rst_n <= 1'b0;
          end
        end
        ST_RUN: begin
          cycle_cnt <= cycle_cnt + 32'd1;
          prev_pc_r <= pc;
          seen_r    <= 1'b1;
          if (pc_same_s) begin
            if (spin_cnt_r != SPIN_LIMIT - 16'd1) begin
              spin_cnt_r <= spin_cnt_r + 16'd1;
            end else begin
              spin_cnt_r <= spin_cnt_r;
            end
            if (spin_cnt_r == SPIN_LIMIT - 16'd2) begin
              spin <= 1'b1;
            end else begin
              spin <= spin;
            end
          end else begin
            spin_cnt_r <= {SPIN_W{1'b0}};
          end
          // hlt takes priority over the cycle limit
          if (hlt) begin
            state_r <= ST_HALTED;
            halt_pc <= pc;
            done    <= 1'b1;
          end else if (cycle_cnt == TIMEOUT_CYCLES - 32'd1) begin
            state_r <= ST_TIMEOUT;
            timeout <= 1'b1;
            done    <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_HALTED, ST_TIMEOUT: begin
          if (restart) begin
            state_r    <= ST_HOLD;
            cpu_rst_n  <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            spin       <= 1'b0;
            cycle_cnt  <= {CNT_W{1'b0}};
            prev_pc_r  <= {PC_W{1'b0}};
            seen_r     <= 1'b0;
            spin_cnt_r <= {SPIN_W{1'b0}};
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r   <= ST_HOLD;
          cpu_rst_n <= 1'b0;
        end
      endcase
    end
  end

`ifdef RUN_MON_TRACE_EN
  logic [PC_W-1:0]        ring_r [TRACE_DEPTH];
  logic [TRACE_IDX_W-1:0] wr_ptr_r;
  logic                   restart_ok_s;

  assign restart_ok_s = restart && ((state_r == ST_HALTED) || (state_r == ST_TIMEOUT));

  // pc history ring: records each new pc during RUN, read back newest-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        ring_r[i] <= {PC_W{1'b0}};
      end
      wr_ptr_r <= {TRACE_IDX_W{1'b0}};
      trace_pc <= {PC_W{1'b0}};
    end else if (restart_ok_s) begin
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        ring_r[i] <= {PC_W{1'b0}};
      end
      wr_ptr_r <= {TRACE_IDX_W{1'b0}};
      trace_pc <= {PC_W{1'b0}};
    end else begin
      if ((state_r == ST_RUN) && !pc_same_s) begin
        ring_r[wr_ptr_r] <= pc;
        wr_ptr_r         <= wr_ptr_r + 3'd1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      trace_pc <= ring_r[trace_slot(wr_ptr_r, trace_idx)];
    end
  end
`else
  logic unused_trace_idx_s;

  assign unused_trace_idx_s = ^trace_idx;
  assign trace_pc           = {PC_W{1'b0}};
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: a vector table of complete runs plus
// hand-written sequences for reset release, restart and the pc history.
module tb_cpu_run_monitor;
  import cpu_run_mon_pkg::*;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        restart   = 1'b0;
  logic        hlt       = 1'b0;
  logic [15:0] pc        = 16'd0;
  logic [2:0]  trace_idx = 3'd0;
  logic        cpu_rst_n;
  logic        done;
  logic        timeout;
  logic        spin;
  logic [15:0] halt_pc;
  logic [31:0] cycle_cnt;
  logic [15:0] trace_pc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          mode;     // 0: pc=base+k, 1: pc=base, 2: base then base+1 from cycle chg
    logic [15:0] base;
    int          chg;
    int          hlt_cyc;  // 0 = never
    int          ncyc;
    logic        exp_done;
    logic        exp_tmo;
    logic        exp_spin;
    logic [15:0] exp_hpc;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  cpu_run_monitor #(
    .RST_HOLD_CYCLES(8'd4),
    .TIMEOUT_CYCLES (32'd20),
    .SPIN_LIMIT     (16'd16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (restart),
    .hlt      (hlt),
    .pc       (pc),
    .cpu_rst_n(cpu_rst_n),
    .done     (done),
    .timeout  (timeout),
    .spin     (spin),
    .halt_pc  (halt_pc),
    .cycle_cnt(cycle_cnt),
    .trace_idx(trace_idx),
    .trace_pc (trace_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pc_at(input int mode, input logic [15:0] base,
                                        input int chg, input int k);
    case (mode)
      0:       return base + 16'(k);
      1:       return base;
      default: return (k < chg) ? base : base + 16'd1;
    endcase
  endfunction

  // Reset pulse, checks of the held values, then the exact release timing.
  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    restart = 1'b0;
    hlt     = 1'b0;
    pc      = 16'd0;
    #2;
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_timeout",   32'(timeout),   32'd0);
    chk("rst_spin",      32'(spin),      32'd0);
    chk("rst_halt_pc",   32'(halt_pc),   32'd0);
    chk("rst_cycle_cnt", cycle_cnt,      32'd0);
    chk("rst_trace_pc",  32'(trace_pc),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // two synchronizer edges, then four hold edges
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("release_edge%0d_cpu_rst_n", e), 32'(cpu_rst_n), (e == 6) ? 32'd1 : 32'd0);
    end
  endtask

  // Drive ncyc RUN cycles, then stop at the next falling edge for sampling.
  task automatic run_cycles(input int mode, input logic [15:0] base, input int chg,
                            input int hlt_cyc, input int ncyc);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      pc  = pc_at(mode, base, chg, k);
      hlt = (k == hlt_cyc);
    end
    @(negedge clk);
    hlt = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_tr;

    vecs[0] = '{0, 16'h0038, 0, 10, 14, 1'b1, 1'b0, 1'b0, 16'h0042, 32'd10};
    vecs[1] = '{0, 16'h0100, 0,  0, 25, 1'b1, 1'b1, 1'b0, 16'h0000, 32'd20};
    vecs[2] = '{0, 16'h0200, 0, 20, 22, 1'b1, 1'b0, 1'b0, 16'h0214, 32'd20};
    vecs[3] = '{1, 16'h0010, 0,  0, 16, 1'b0, 1'b0, 1'b1, 16'h0000, 32'd16};
    vecs[4] = '{1, 16'h0010, 0,  0, 15, 1'b0, 1'b0, 1'b0, 16'h0000, 32'd15};
    vecs[5] = '{2, 16'h0010, 8,  0, 16, 1'b0, 1'b0, 1'b0, 16'h0000, 32'd16};
    vecs[6] = '{1, 16'h1234, 0,  1,  3, 1'b1, 1'b0, 1'b0, 16'h1234, 32'd1};
    vecs[7] = '{1, 16'h0010, 0, 18, 19, 1'b1, 1'b0, 1'b1, 16'h0010, 32'd18};

    // Table of complete runs, each from a fresh reset.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      run_cycles(vecs[v].mode, vecs[v].base, vecs[v].chg, vecs[v].hlt_cyc, vecs[v].ncyc);
      chk($sformatf("v%0d_done", v),      32'(done),    32'(vecs[v].exp_done));
      chk($sformatf("v%0d_timeout", v),   32'(timeout), 32'(vecs[v].exp_tmo));
      chk($sformatf("v%0d_spin", v),      32'(spin),    32'(vecs[v].exp_spin));
      chk($sformatf("v%0d_halt_pc", v),   32'(halt_pc), 32'(vecs[v].exp_hpc));
      chk($sformatf("v%0d_cycle_cnt", v), cycle_cnt,    vecs[v].exp_cnt);
    end

    // Restart during RUN is ignored, then halt and restart from HALTED.
    do_reset();
    run_cycles(0, 16'h0300, 0, 0, 3);
    restart = 1'b1;
    pc      = 16'h0400;
    @(negedge clk);
    restart = 1'b0;
    chk("run_restart_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("run_restart_cycle_cnt", cycle_cnt,      32'd4);
    hlt = 1'b1;
    pc  = 16'h0ABC;
    @(negedge clk);
    hlt = 1'b0;
    chk("halt_done",      32'(done),    32'd1);
    chk("halt_pc_cap",    32'(halt_pc), 32'h0ABC);
    chk("halt_cycle_cnt", cycle_cnt,    32'd5);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("rs_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rs_cycle_cnt", cycle_cnt,      32'd0);
    chk("rs_done",      32'(done),      32'd0);
    chk("rs_halt_pc",   32'(halt_pc),   32'h0ABC);
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      chk($sformatf("rs_hold%0d_cpu_rst_n", e), 32'(cpu_rst_n), (e == 4) ? 32'd1 : 32'd0);
    end

    // Timeout, then restart from TIMEOUT with restart held high through HOLD.
    run_cycles(0, 16'h0500, 0, 0, 20);
    chk("tmo_timeout", 32'(timeout), 32'd1);
    chk("tmo_halt_pc", 32'(halt_pc), 32'h0ABC);
    restart = 1'b1;
    @(negedge clk);
    chk("tmo_rs_timeout",   32'(timeout),   32'd0);
    chk("tmo_rs_done",      32'(done),      32'd0);
    chk("tmo_rs_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      chk($sformatf("tmo_hold%0d_cpu_rst_n", e), 32'(cpu_rst_n), (e == 4) ? 32'd1 : 32'd0);
      if (e == 3) begin
        restart = 1'b0;
      end
    end

    // Asynchronous reset in the middle of a run.
    run_cycles(0, 16'h0600, 0, 0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("async_cycle_cnt", cycle_cnt,      32'd0);
    chk("async_halt_pc",   32'(halt_pc),   32'd0);

    // pc history: sequence 1..10 reads back newest-first.
    do_reset();
    run_cycles(0, 16'h0000, 0, 0, 10);
    for (int i = 0; i < 8; i++) begin
      trace_idx = 3'(i);
      @(negedge clk);
`ifdef RUN_MON_TRACE_EN
      exp_tr = 16'(10 - i);
`else
      exp_tr = 16'd0;
`endif
      chk($sformatf("trace_idx%0d", i), 32'(trace_pc), 32'(exp_tr));
    end

    // Unwritten ring entries read 0.
    do_reset();
    run_cycles(0, 16'h0000, 0, 0, 3);
    trace_idx = 3'd0;
    @(negedge clk);
`ifdef RUN_MON_TRACE_EN
    exp_tr = 16'd3;
`else
    exp_tr = 16'd0;
`endif
    chk("trace_short_newest", 32'(trace_pc), 32'(exp_tr));
    trace_idx = 3'd3;
    @(negedge clk);
    chk("trace_short_unwritten", 32'(trace_pc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
